mips_fwd_ctrl: RTL

- Forwarding and hazard controller for the 5-stage MIPS pipeline.
- Produces the 2-bit forward selects `fa` and `fb` consumed by the EX-stage ALU operand muxes. It also produces the load-use stall/bubble request.
- Tracks destination registers of in-flight instructions in an internal shadow pipeline (EX, MEM, WB). Sits beside the ID/EX pipeline register in `mips`.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/mips_dest_decode.sv | 47 ++++
 rtl/mips_fwd_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared opcodes, forward-select encodings and the shadow-pipeline entry type
// for the MIPS forwarding/hazard controller.
package mips_pkg;

    localparam int unsigned RegW = 5;

    localparam logic [5:0] ALUop   = 6'h00;
    localparam logic [5:0] Jop     = 6'h02;
    localparam logic [5:0] JALop   = 6'h03;
    localparam logic [5:0] ADD_IMM = 6'h08;
    localparam logic [5:0] LW      = 6'h23;
    localparam logic [5:0] SW      = 6'h2B;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic [RegW-1:0] dest;
        logic            is_load;
    } shadow_t;

endpackage

// File: rtl/mips_dest_decode.sv
// Opcode decode: destination register, which source fields are read, and
// whether the instruction is a load.
module mips_dest_decode
    import mips_pkg::*;
#(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned LINK_REG = 31
) (
    input  logic [5:0]       op_i,
    input  logic [REG_W-1:0] rt_i,
    input  logic [REG_W-1:0] rd_i,
    output logic [REG_W-1:0] dest_o,
    output logic             uses_rs_o,
    output logic             uses_rt_o,
    output logic             is_load_o
);

    always_comb begin
        dest_o    = '0;
        uses_rs_o = 1'b0;
        uses_rt_o = 1'b0;
        is_load_o = 1'b0;
        case (op_i)
            ALUop: begin
                dest_o    = rd_i;
                uses_rs_o = 1'b1;
                uses_rt_o = 1'b1;
            end
            LW: begin
                dest_o    = rt_i;
                uses_rs_o = 1'b1;
                is_load_o = 1'b1;
            end
            ADD_IMM: begin
                dest_o    = rt_i;
                uses_rs_o = 1'b1;
            end
            SW: begin
                uses_rs_o = 1'b1;
                uses_rt_o = 1'b1;
            end
            JALop:   dest_o = REG_W'(LINK_REG);
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_fwd_ctrl.sv
// EX-stage forwarding selects and load-use stall for the 5-stage MIPS pipeline.
// Define MIPS_FWD_STALL_CNT_EN to add the stall_count / fwd_count counters.
module mips_fwd_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned REG_W    = RegW,
    parameter int unsigned LINK_REG = 31
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [5:0]       id_op,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    output logic             stall,
    output logic [1:0]       fa,
    output logic [1:0]       fb,
    output logic [REG_W-1:0] ex_dest
`ifdef MIPS_FWD_STALL_CNT_EN
    ,
    output logic [31:0]      stall_count,
    output logic [31:0]      fwd_count
`endif
);

    logic [REG_W-1:0] dec_dest;
    logic             uses_rs, uses_rt, dec_load;
    logic             issue;
    shadow_t          ex_q, ex_d, mem_q, wb_q;
    logic [1:0]       fa_q, fa_d, fb_q, fb_d;

    mips_dest_decode #(
        .REG_W    (REG_W),
        .LINK_REG (LINK_REG)
    ) u_dec (
        .op_i      (id_op),
        .rt_i      (id_rt),
        .rd_i      (id_rd),
        .dest_o    (dec_dest),
        .uses_rs_o (uses_rs),
        .uses_rt_o (uses_rt),
        .is_load_o (dec_load)
    );

    // Register 0 never counts as a producer, so an unused or $0 source cannot match.
    function automatic logic hit(shadow_t e, logic used, logic [REG_W-1:0] src);
        return used && (e.dest != '0) && (e.dest == src);
    endfunction

    function automatic logic [1:0] sel(shadow_t ex, shadow_t mem, logic used,
                                       logic [REG_W-1:0] src);
        if (hit(ex, used, src))       return FWD_MEM;
        else if (hit(mem, used, src)) return FWD_WB;
        else                          return FWD_REG;
    endfunction

    always_comb begin
        stall = reset_n && id_valid && ex_q.is_load &&
                (hit(ex_q, uses_rs, id_rs) || hit(ex_q, uses_rt, id_rt));
        issue = id_valid && !stall;
        ex_d  = '0;
        fa_d  = FWD_REG;
        fb_d  = FWD_REG;
        if (issue) begin
            ex_d.dest    = dec_dest;
            ex_d.is_load = dec_load;
            fa_d         = sel(ex_q, mem_q, uses_rs, id_rs);
            fb_d         = sel(ex_q, mem_q, uses_rt, id_rt);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            fa_q  <= FWD_REG;
            fb_q  <= FWD_REG;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            fa_q  <= fa_d;
            fb_q  <= fb_d;
        end
    end

    assign fa      = fa_q;
    assign fb      = fb_q;
    assign ex_dest = ex_q.dest;

`ifdef MIPS_FWD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, fwd_cnt_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall)                               stall_cnt_q <= stall_cnt_q + 32'd1;
            if ((fa_d != FWD_REG) || (fb_d != FWD_REG)) fwd_cnt_q <= fwd_cnt_q + 32'd1;
        end
    end

    assign stall_count = stall_cnt_q;
    assign fwd_count   = fwd_cnt_q;
`endif

endmodule
